pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline controller for the 5-stage RV32I core. Arbitrates stall requests from IF/ID/EX/MEM into the
//  6-bit stall vector consumed by pc_reg and all inter-stage registers (if_id, id_ex, ...). Sequences
//  flush+redirect on EX branch mispredict or MEM trap, and watches for a hung pipeline.
//  Sits beside the datapath, no data through it; one instance per core.
// PARAMETERS
//  WDT_LIMIT   1024  consecutive stalled cycles before stall_timeout_o sets (>=2)
//  WDT_W       11    watchdog counter width; must hold WDT_LIMIT
// PORTS
//  clk               in   1   clock, rising edge
//  rst_n             in   1   reset, synchronous, active-low
//  stallreq_if_i     in   1   IF stall (fetch miss)
//  stallreq_id_i     in   1   ID stall (load-use)
//  stallreq_ex_i     in   1   EX stall (multi-cycle mul/div busy)
//  stallreq_mem_i    in   1   MEM stall (data access wait)
//  ex_mispredict_i   in   1   EX resolved branch disagrees with if_prediction
//  ex_target_i       in   32  correct next pc for mispredict
//  mem_trap_i        in   1   MEM raises trap
//  mem_trap_vec_i    in   32  trap handler pc
//  stall_o           out  6   [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1=stall
//  flush_o           out  1   clear if_id, id_ex, ex_mem to bubbles
//  redirect_valid_o  out  1   pc_reg loads redirect_pc_o this cycle
//  redirect_pc_o     out  32  redirect target
//  stall_timeout_o   out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=RUN, stall_o=0, flush_o=0, redirect_valid_o=0, redirect_pc_o=0,
//   stall_timeout_o=0, watchdog count=0. Reset mid-flush discards pending redirect.
//  Stall vector (combinational in RUN), highest-stage request wins:
//   mem ->6'b011111; ex ->6'b001111; id ->6'b000111; if ->6'b000011; none ->6'b000000.
//   Stage k stalled with k+1 running => that register emits a bubble (existing if_id rule).
//  Events: trap has priority over mispredict when both in same cycle. Event sampled only when
//   stallreq_mem_i=0 (MEM/EX stalled -> event held by source, re-sampled next cycle).
//  FSM RUN/FLUSH:
//   RUN: event at edge N -> latch target (trap vec or ex_target), go FLUSH.
//   FLUSH (cycle N+1, exactly 1 cycle): flush_o=1, redirect_valid_o=1, redirect_pc_o=latched,
//    stall_o=0 regardless of requests (stalled work is being killed); events ignored; -> RUN.
//   Latency event->redirect = 1 cycle; redirect outputs registered, no comb path from event inputs.
//   Back-to-back: new event in first RUN cycle after FLUSH is accepted normally.
//  redirect_pc_o holds last target outside FLUSH; only valid with redirect_valid_o.
//  Watchdog: count++ (saturating) each cycle stall_o!=0; cleared when stall_o==0 or in FLUSH.
//   count reaching WDT_LIMIT sets stall_timeout_o; stays 1 until reset. Stalls not altered by it.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cyc_o[31:0] (cycles with stall_o!=0),
//   perf_flush_cnt_o[31:0] (FLUSH entries); both reset to 0, wrap 0xFFFFFFFF->0, count
//   registered (visible cycle after event).
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 stallreq_id_i=1 for 2 cycles, others 0 -> stall_o=6'b000111 both cycles, then 0; flush_o=0.
//  2 stallreq_if_i=1 & stallreq_ex_i=1 same cycle -> stall_o=6'b001111.
//  3 ex_mispredict_i=1, ex_target_i=0x0000_0100 at edge N -> cycle N+1 flush_o=1,
//    redirect_valid_o=1, redirect_pc_o=0x100, stall_o=0; cycle N+2 flush_o=0.
//  4 mem_trap_i=1 vec=0x8000_0000 with ex_mispredict_i=1 target=0x200 -> redirect_pc_o=0x8000_0000.
//  5 WDT_LIMIT=4, stallreq_mem_i held 1 -> stall_timeout_o=1 after 4th stalled cycle; release
//    -> flag stays 1 until rst_n=0.
//  6 rst_n=0 the cycle after a mispredict -> no flush/redirect; all outputs 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the RV32I datapath and pipe_ctrl: stall requests and redirect events in,
// stall vector, flush and redirect controls out.
interface pipe_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        ex_mispredict_i;
  logic [31:0] ex_target_i;
  logic        mem_trap_i;
  logic [31:0] mem_trap_vec_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        stall_timeout_o;

  // Datapath side: raises requests/events, consumes the controls.
  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output ex_mispredict_i, ex_target_i, mem_trap_i, mem_trap_vec_i,
    input  stall_o, flush_o, redirect_valid_o, redirect_pc_o, stall_timeout_o
  );

  // Controller side.
  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  ex_mispredict_i, ex_target_i, mem_trap_i, mem_trap_vec_i,
    output stall_o, flush_o, redirect_valid_o, redirect_pc_o, stall_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage RV32I core: stall arbitration, flush+redirect sequencing, hang watchdog.
// Optional PIPE_CTRL_PERF_EN adds stall-cycle and flush-entry performance counters.
module pipe_ctrl #(
  parameter int WDT_LIMIT = 1024,
  parameter int WDT_W     = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);

  logic [0:0]       state_q, state_d;
  logic [31:0]      redirect_pc_q;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             timeout_q;
  logic [5:0]       stall_run;
  logic [5:0]       stall_vec;
  logic             stalling;
  logic             event_take;
  logic [31:0]      event_target;

  // Highest stalled stage freezes itself and every stage upstream of it.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stall_run = 6'b000000;
    if (bus.stallreq_mem_i)     stall_run = 6'b011111;
    else if (bus.stallreq_ex_i) stall_run = 6'b001111;
    else if (bus.stallreq_id_i) stall_run = 6'b000111;
    else if (bus.stallreq_if_i) stall_run = 6'b000011;
  end

  // During FLUSH the stalled work is being discarded, so nothing is held.
  assign stall_vec = (state_q == ST_FLUSH) ? 6'b000000 : stall_run;
  assign stalling  = (stall_vec != 6'b000000);

  // A busy MEM stage keeps the event source holding its request; take it once MEM moves.
  assign event_take   = (state_q == ST_RUN) && !bus.stallreq_mem_i &&
                        (bus.mem_trap_i || bus.ex_mispredict_i);
  assign event_target = bus.mem_trap_i ? bus.mem_trap_vec_i : bus.ex_target_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (event_take) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Watchdog counts consecutive stalled cycles and saturates at the limit.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    if (state_q == ST_FLUSH || !stalling) wdt_cnt_d = '0;
    else if (wdt_cnt_q != WDT_MAX)        wdt_cnt_d = wdt_cnt_q + 1'b1;
  end

  // NOTE: control state uses a synchronous active-low reset to match the rest of the core; every
  // register here is reset because a stale redirect after reset would steer fetch to garbage.
  // NOTE: sequential state is updated with non-blocking assignments only, so registers read
  // within the same edge see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      redirect_pc_q <= 32'h0;
      wdt_cnt_q     <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdt_cnt_q <= wdt_cnt_d;
      if (event_take) redirect_pc_q <= event_target;
      if (wdt_cnt_d == WDT_MAX) timeout_q <= 1'b1;
    end
  end

  assign bus.stall_o          = stall_vec;
  assign bus.flush_o          = (state_q == ST_FLUSH);
  assign bus.redirect_valid_o = (state_q == ST_FLUSH);
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.stall_timeout_o  = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_q;
  logic [31:0] perf_flush_cnt_q;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cyc_q <= 32'h0;
      perf_flush_cnt_q <= 32'h0;
    end else begin
      if (stalling)   perf_stall_cyc_q <= perf_stall_cyc_q + 32'd1;
      if (event_take) perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cyc_o = perf_stall_cyc_q;
  assign perf_flush_cnt_o = perf_flush_cnt_q;
`endif

  // FLUSH is a single-cycle state.
  a_flush_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_FLUSH) |=> (state_q == ST_RUN));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model pushes expected outputs per driven cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  localparam int TB_LIMIT = 4;
  localparam int TB_W     = 3;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic        rvalid;
    logic [31:0] pc;
    logic        timeout;
    logic [31:0] pstall;
    logic [31:0] pflush;
  } exp_t;

  logic clk;
  logic rst_n;
  pipe_ctrl_if intf ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_ctrl #(.WDT_LIMIT(TB_LIMIT), .WDT_W(TB_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cyc_o (perf_stall_cyc),
    .perf_flush_cnt_o (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  // Reference model state.
  bit          m_valid = 1'b0;
  bit          m_flush = 1'b0;
  logic [31:0] m_pc    = 32'h0;
  int          m_cnt   = 0;
  bit          m_to    = 1'b0;
  logic [31:0] m_ps    = 32'h0;
  logic [31:0] m_pf    = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_stall(input bit flushing, input logic [3:0] r);
    if (flushing) return 6'b000000;
    if (r[3]) return 6'b011111;
    if (r[2]) return 6'b001111;
    if (r[1]) return 6'b000111;
    if (r[0]) return 6'b000011;
    return 6'b000000;
  endfunction

  function automatic logic [3:0] cur_req();
    return {intf.stallreq_mem_i, intf.stallreq_ex_i, intf.stallreq_id_i, intf.stallreq_if_i};
  endfunction

  // Advance the model over one rising edge using the inputs that were applied during the cycle.
  task automatic model_edge();
    logic [5:0] s;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_flush = 1'b0;
      m_pc    = 32'h0;
      m_cnt   = 0;
      m_to    = 1'b0;
      m_ps    = 32'h0;
      m_pf    = 32'h0;
    end else if (m_valid) begin
      s = exp_stall(m_flush, cur_req());
      if (s != 6'b0) m_ps = m_ps + 32'd1;
      if (m_flush) begin
        m_flush = 1'b0;
        m_cnt   = 0;
      end else begin
        if (!intf.stallreq_mem_i && (intf.mem_trap_i || intf.ex_mispredict_i)) begin
          m_flush = 1'b1;
          m_pc    = intf.mem_trap_i ? intf.mem_trap_vec_i : intf.ex_target_i;
          m_pf    = m_pf + 32'd1;
        end
        if (s != 6'b0) begin
          if (m_cnt < TB_LIMIT) m_cnt++;
        end else begin
          m_cnt = 0;
        end
        if (m_cnt >= TB_LIMIT) m_to = 1'b1;
      end
    end
  endtask

  // One cycle: edge, model update, apply new inputs, push expected outputs for this cycle.
  task automatic drive(input logic rst, input logic [3:0] req, input logic mis,
                       input logic [31:0] tgt, input logic trap, input logic [31:0] vec);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst_n                = rst;
    intf.stallreq_mem_i  = req[3];
    intf.stallreq_ex_i   = req[2];
    intf.stallreq_id_i   = req[1];
    intf.stallreq_if_i   = req[0];
    intf.ex_mispredict_i = mis;
    intf.ex_target_i     = tgt;
    intf.mem_trap_i      = trap;
    intf.mem_trap_vec_i  = vec;
    if (m_valid) begin
      e.stall   = exp_stall(m_flush, req);
      e.flush   = m_flush;
      e.rvalid  = m_flush;
      e.pc      = m_pc;
      e.timeout = m_to;
      e.pstall  = m_ps;
      e.pflush  = m_pf;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic reqs(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, r, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("stall_o",          {26'h0, intf.stall_o},          {26'h0, e.stall});
      check("flush_o",          {31'h0, intf.flush_o},          {31'h0, e.flush});
      check("redirect_valid_o", {31'h0, intf.redirect_valid_o}, {31'h0, e.rvalid});
      if (e.rvalid) check("redirect_pc_o", intf.redirect_pc_o, e.pc);
      check("stall_timeout_o",  {31'h0, intf.stall_timeout_o},  {31'h0, e.timeout});
`ifdef PIPE_CTRL_PERF_EN
      check("perf_stall_cyc_o", perf_stall_cyc, e.pstall);
      check("perf_flush_cnt_o", perf_flush_cnt, e.pflush);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got run still active expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n                = 1'b0;
    intf.stallreq_if_i   = 1'b0;
    intf.stallreq_id_i   = 1'b0;
    intf.stallreq_ex_i   = 1'b0;
    intf.stallreq_mem_i  = 1'b0;
    intf.ex_mispredict_i = 1'b0;
    intf.ex_target_i     = 32'h0;
    intf.mem_trap_i      = 1'b0;
    intf.mem_trap_vec_i  = 32'h0;

    drive(1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);

    // Load-use stall for two cycles, then release.
    reqs(4'b0010, 2);
    idle(1);
    // IF+EX together: EX wins; then each request alone and mixes.
    reqs(4'b0101, 1);
    reqs(4'b1000, 1);
    reqs(4'b0100, 1);
    reqs(4'b0001, 1);
    reqs(4'b1010, 1);
    reqs(4'b1111, 1);
    idle(1);

    // Mispredict redirect, then trap beating a simultaneous mispredict.
    drive(1'b1, 4'b0000, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    idle(2);
    drive(1'b1, 4'b0000, 1'b1, 32'h0000_0200, 1'b1, 32'h8000_0000);
    idle(2);

    // Event held while MEM stalls, taken once MEM releases.
    drive(1'b1, 4'b1000, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    drive(1'b1, 4'b1000, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    drive(1'b1, 4'b0000, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    idle(2);

    // Requests and events during FLUSH are ignored; first RUN cycle after accepts again.
    drive(1'b1, 4'b0000, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
    drive(1'b1, 4'b1111, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0540);
    drive(1'b1, 4'b0000, 1'b1, 32'h0000_0600, 1'b0, 32'h0);
    idle(2);

    // Watchdog just below the limit, cleared by a gap and by FLUSH.
    reqs(4'b0010, 3);
    idle(1);
    reqs(4'b0010, 2);
    drive(1'b1, 4'b0010, 1'b1, 32'h0000_0680, 1'b0, 32'h0);
    reqs(4'b0010, 3);
    idle(1);

    // Watchdog trips after the 4th stalled cycle and stays sticky.
    reqs(4'b1000, 6);
    idle(3);

    // Reset while a redirect is in FLUSH, then reset on the edge that samples a mispredict.
    drive(1'b1, 4'b0000, 1'b1, 32'h0000_0700, 1'b0, 32'h0);
    drive(1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(2);
    drive(1'b0, 4'b0000, 1'b1, 32'h0000_0900, 1'b0, 32'h0);
    idle(2);

    // Random mix of requests and sparse events.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] r;
      logic       mis, trap;
      r    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      mis  = ($urandom_range(0, 5) == 0);
      trap = ($urandom_range(0, 9) == 0);
      drive(1'b1, r, mis, $urandom, trap, $urandom);
    end
    idle(2);

    @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
